// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: opcode-driven TXDATA/CTRL writes, STATUS/FRAMES reads,
// a small TX FIFO and a registered serializer on txd.
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 16,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  opcode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        fifo_full
);

    // state   | meaning
    // S_IDLE  | line high, waiting for a FIFO entry
    // S_START | start bit (low) for one bit period
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit (high); may chain straight into the next start bit
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OP_WR_DATA = 3'd0;
    localparam logic [2:0] OP_WR_CTRL = 3'd1;
    localparam logic [2:0] OP_RD_STAT = 3'd2;
    localparam logic [2:0] OP_RD_FRM  = 3'd3;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             fifo_empty;
    logic             push, pop;

    logic [DIV_W-1:0] div_q;
    logic             ovf_q;
    logic [31:0]      frames_q;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             bit_end;
    logic             frame_done;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign push       = (opcode == OP_WR_DATA) && (!fifo_full || pop);
    assign bit_end    = (timer_q == div_lat_q - 1'b1);
    assign txd        = txd_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= DIV_W'(DEFAULT_DIV);
            ovf_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            if (opcode == OP_WR_CTRL) begin
                // A divisor below 2 cannot form a usable bit period.
                div_q <= (wdata[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : wdata[DIV_W-1:0];
                if (wdata[31]) begin
                    ovf_q <= 1'b0;
                end
            end else if ((opcode == OP_WR_DATA) && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (frame_done) begin
                frames_q <= frames_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            div_lat_q <= DIV_W'(DEFAULT_DIV);
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_lat_q <= div_lat_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        div_lat_d  = div_lat_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    div_lat_d = div_q;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    timer_d    = '0;
                    frame_done = 1'b1;
                    // Chain the next frame directly so there is no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        div_lat_d = div_q;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // txd is registered from the next state so the line never glitches.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (opcode)
            OP_RD_STAT: rdata = {23'd0, 5'(count_q), ovf_q, (state_q != S_IDLE), fifo_full, fifo_empty};
            OP_RD_FRM:  rdata = frames_q;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: one task per scenario, txd captured once per clock
// and compared against hand-built frame waveforms.
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic [2:0]  opcode;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        txd;
    logic        fifo_full;

    int checks   = 0;
    int failures = 0;

    logic cap_en = 1'b0;
    logic cap[$];
    logic exp_q[$];

    mmio_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16), .DIV_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .wdata     (wdata),
        .rdata     (rdata),
        .txd       (txd),
        .fifo_full (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One txd sample per clock, taken just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (cap_en) cap.push_back(txd);
    end

    // All stimulus tasks start and end at (or just after) a falling edge.
    task automatic wr(input logic [2:0] op, input logic [31:0] d);
        opcode = op;
        wdata  = d;
        @(negedge clk);
        opcode = 3'd4;
        wdata  = '0;
    endtask

    task automatic rd(input logic [2:0] op, output logic [31:0] d);
        opcode = op;
        #1;
        d = rdata;
        opcode = 3'd4;
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < div; j++) exp_q.push_back(v);
        end
    endtask

    task automatic add_idle(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(1'b1);
    endtask

    task automatic start_capture();
        cap.delete();
        exp_q.delete();
        cap_en = 1'b1;
        exp_q.push_back(1'b1);
    endtask

    task automatic wait_cap(input int need);
        for (int i = 0; i < 5000 && cap.size() < need; i++) @(negedge clk);
        cap_en = 1'b0;
    endtask

    function automatic logic cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 1'bx;
    endfunction

    function automatic int wave_bad_first();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cap_at(i) !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        int lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL reset_idle_txd: low cycles=%0d required=0", lows);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL reset_status: got %h required %h", d, 32'h1);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_frames: got %h required %h", d, 32'h0);
        end
        checks++;
        if (fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full: got %b required 0", fifo_full);
        end
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata_op4: got %h required 0", rdata);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        int f;
        @(negedge clk);
        wr(3'd1, 32'd4);
        start_capture();
        wr(3'd0, 32'h0000_00A5);
        add_frame(8'hA5, 4);
        add_idle(2);
        wait_cap(exp_q.size());
        f = wave_bad_first();
        checks++;
        if (f >= 0) begin
            failures++;
            $display("FAIL a5_wave: sample %0d got %b required %b", f, cap_at(f), exp_q[f]);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL a5_frames: got %0d required 1", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0] bytes [5];
        int f;
        bytes[0] = 8'h11; bytes[1] = 8'h82; bytes[2] = 8'hF0;
        bytes[3] = 8'h0F; bytes[4] = 8'h6B;
        @(negedge clk);
        wr(3'd1, 32'd2);
        start_capture();
        for (int i = 0; i < 6; i++) begin
            opcode = 3'd0;
            wdata  = (i < 5) ? {24'd0, bytes[i]} : 32'h0000_00EE;
            @(negedge clk);
        end
        opcode = 3'd4;
        wdata  = '0;
        checks++;
        if (fifo_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full_pin: got %b required 1", fifo_full);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 32'h0000_004E) begin
            failures++;
            $display("FAIL b2b_status: got %h required %h", d, 32'h4E);
        end
        for (int i = 0; i < 5; i++) add_frame(bytes[i], 2);
        add_idle(4);
        wait_cap(exp_q.size());
        f = wave_bad_first();
        checks++;
        if (f >= 0) begin
            failures++;
            $display("FAIL b2b_wave: sample %0d got %b required %b", f, cap_at(f), exp_q[f]);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'd6) begin
            failures++;
            $display("FAIL b2b_frames: got %0d required 6", d);
        end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] d;
        int f;
        @(negedge clk);
        wr(3'd1, 32'h8000_0000);
        rd(3'd2, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL ovf_clear_status: got %h required %h", d, 32'h1);
        end
        @(negedge clk);
        start_capture();
        wr(3'd0, 32'h0000_003C);
        add_frame(8'h3C, 2);
        add_idle(3);
        wait_cap(exp_q.size());
        f = wave_bad_first();
        checks++;
        if (f >= 0) begin
            failures++;
            $display("FAIL div0_wave: sample %0d got %b required %b", f, cap_at(f), exp_q[f]);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'd7) begin
            failures++;
            $display("FAIL div0_frames: got %0d required 7", d);
        end
    endtask

    task automatic test_div_change();
        logic [31:0] d;
        int f;
        @(negedge clk);
        wr(3'd1, 32'd8);
        start_capture();
        wr(3'd0, 32'h0000_005A);
        repeat (20) @(negedge clk);
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h0000_00C3);
        add_frame(8'h5A, 8);
        add_frame(8'hC3, 3);
        add_idle(4);
        wait_cap(exp_q.size());
        f = wave_bad_first();
        checks++;
        if (f >= 0) begin
            failures++;
            $display("FAIL divchg_wave: sample %0d got %b required %b", f, cap_at(f), exp_q[f]);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'd9) begin
            failures++;
            $display("FAIL divchg_frames: got %0d required 9", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int f;
        @(negedge clk);
        wr(3'd0, 32'h0000_0000);
        repeat (6) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            failures++;
            $display("FAIL mid_data_txd: got %b required 0", txd);
        end
        rd(3'd2, d);
        checks++;
        if (d !== 32'h5) begin
            failures++;
            $display("FAIL mid_data_status: got %h required %h", d, 32'h5);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_txd: got %b required 1", txd);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(3'd2, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL post_reset_status: got %h required %h", d, 32'h1);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_frames: got %0d required 0", d);
        end
        for (int op = 4; op < 8; op++) begin
            opcode = 3'(op);
            wdata  = 32'hFFFF_FFFF;
            #1;
            checks++;
            if (rdata !== 32'h0) begin
                failures++;
                $display("FAIL noop_rdata_op%0d: got %h required 0", op, rdata);
            end
            @(negedge clk);
        end
        opcode = 3'd4;
        wdata  = '0;
        rd(3'd2, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL noop_status: got %h required %h", d, 32'h1);
        end
        @(negedge clk);
        start_capture();
        wr(3'd0, 32'h0000_0096);
        add_frame(8'h96, 16);
        add_idle(2);
        wait_cap(exp_q.size());
        f = wave_bad_first();
        checks++;
        if (f >= 0) begin
            failures++;
            $display("FAIL default_div_wave: sample %0d got %b required %b", f, cap_at(f), exp_q[f]);
        end
        rd(3'd3, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL default_div_frames: got %0d required 1", d);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 3'd4;
        wdata  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow_clear();
        test_div_change();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
